// File: rtl/lc3_exec_pkg.sv
// Shared types, opcodes and helpers for the LC3 execute stage.
package lc3_exec_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned RW  = 3;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_BR  = 4'b0000;
  localparam logic [OPW-1:0] OP_ADD = 4'b0001;
  localparam logic [OPW-1:0] OP_LD  = 4'b0010;
  localparam logic [OPW-1:0] OP_ST  = 4'b0011;
  localparam logic [OPW-1:0] OP_AND = 4'b0101;
  localparam logic [OPW-1:0] OP_LDR = 4'b0110;
  localparam logic [OPW-1:0] OP_STR = 4'b0111;
  localparam logic [OPW-1:0] OP_NOT = 4'b1001;
  localparam logic [OPW-1:0] OP_LDI = 4'b1010;
  localparam logic [OPW-1:0] OP_STI = 4'b1011;
  localparam logic [OPW-1:0] OP_JMP = 4'b1100;
  localparam logic [OPW-1:0] OP_LEA = 4'b1110;

  // E_control field positions
  localparam int unsigned EC_ALU_LSB    = 4;
  localparam int unsigned EC_PCSEL1_LSB = 2;
  localparam int unsigned EC_PCSEL2     = 1;
  localparam int unsigned EC_OP2SEL     = 0;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_e;

  // Pipeline register payload handed to memaccess/writeback
  typedef struct packed {
    logic [DW-1:0] aluout;
    logic [DW-1:0] pcout;
    logic [RW-1:0] dr;
    logic [DW-1:0] ir;
    logic [2:0]    nzp;
    logic [1:0]    w_control;
    logic          mem_control;
    logic [DW-1:0] m_data;
  } exec_out_t;

  function automatic logic [DW-1:0] sext5(input logic [4:0] v);
    return {{(DW-5){v[4]}}, v};
  endfunction

  function automatic logic [DW-1:0] sext6(input logic [5:0] v);
    return {{(DW-6){v[5]}}, v};
  endfunction

  function automatic logic [DW-1:0] sext9(input logic [8:0] v);
    return {{(DW-9){v[8]}}, v};
  endfunction

  function automatic logic [DW-1:0] sext11(input logic [10:0] v);
    return {{(DW-11){v[10]}}, v};
  endfunction

endpackage

// File: rtl/lc3_exec_alu.sv
// Combinational LC3 ALU: ADD, AND, NOT and pass-through of operand a.
module lc3_exec_alu
  import lc3_exec_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  alu_op_e       op_i,
  output logic [DW-1:0] result_c
);

  always_comb begin
    result_c = '0;
    case (op_i)
      ALU_ADD:  result_c = a_i + b_i;
      ALU_AND:  result_c = a_i & b_i;
      ALU_NOT:  result_c = ~a_i;
      ALU_PASS: result_c = a_i;
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/lc3_execute.sv
// LC3 execute stage: operand bypass, ALU, effective address and the
// pipeline register feeding memaccess/writeback.
module lc3_execute
  import lc3_exec_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_execute,
  input  logic [DW-1:0] IR,
  input  logic [DW-1:0] npc_in,
  input  logic [5:0]    E_control,
  input  logic [1:0]    W_control_in,
  input  logic          Mem_control_in,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  input  logic          bypass_alu_1,
  input  logic          bypass_alu_2,
  input  logic          bypass_mem_1,
  input  logic          bypass_mem_2,
  input  logic [DW-1:0] Mem_bypass_val,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] pcout,
  output logic [RW-1:0] dr,
  output logic [RW-1:0] sr1,
  output logic [RW-1:0] sr2,
  output logic [DW-1:0] IR_Exec,
  output logic [2:0]    NZP,
  output logic [1:0]    W_control_out,
  output logic          Mem_control_out,
  output logic [DW-1:0] M_Data
);

  exec_out_t      exec_q, exec_d;
  logic [OPW-1:0] opcode;
  logic [DW-1:0]  op1, op2, alu_b, alu_res;
  logic [DW-1:0]  addr_base, addr_off, addr_sum;
  logic [RW-1:0]  dr_nxt;
  logic [2:0]     nzp_nxt;

  assign opcode = IR[15:12];

  // Source indexes go straight to the regfile; stores read the data reg via sr2
  always_comb begin
    sr1 = IR[8:6];
    sr2 = IR[2:0];
    if (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) begin
      sr2 = IR[11:9];
    end
  end

  // Forwarding: the registered ALU result has priority over the memory value
  always_comb begin
    op1 = VSR1;
    op2 = VSR2;
    if (bypass_alu_1)      op1 = exec_q.aluout;
    else if (bypass_mem_1) op1 = Mem_bypass_val;
    if (bypass_alu_2)      op2 = exec_q.aluout;
    else if (bypass_mem_2) op2 = Mem_bypass_val;
    alu_b = E_control[EC_OP2SEL] ? op2 : sext5(IR[4:0]);
  end

  lc3_exec_alu u_alu (
    .a_i      (op1),
    .b_i      (alu_b),
    .op_i     (alu_op_e'(E_control[EC_ALU_LSB +: 2])),
    .result_c (alu_res)
  );

  always_comb begin
    addr_off = '0;
    case (E_control[EC_PCSEL1_LSB +: 2])
      2'b00:   addr_off = sext11(IR[10:0]);
      2'b01:   addr_off = sext9(IR[8:0]);
      2'b10:   addr_off = sext6(IR[5:0]);
      default: addr_off = '0;
    endcase
    addr_base = E_control[EC_PCSEL2] ? npc_in : op1;
    addr_sum  = addr_base + addr_off;
  end

  always_comb begin
    dr_nxt  = '0;
    nzp_nxt = '0;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA: dr_nxt = IR[11:9];
      default: dr_nxt = '0;
    endcase
    case (opcode)
      OP_BR:   nzp_nxt = IR[11:9];
      OP_JMP:  nzp_nxt = 3'b111;
      default: nzp_nxt = '0;
    endcase
  end

  always_comb begin
    exec_d = exec_q;
    if (enable_execute) begin
      exec_d.aluout      = (opcode == OP_LEA) ? addr_sum : alu_res;
      exec_d.pcout       = addr_sum;
      exec_d.dr          = dr_nxt;
      exec_d.ir          = IR;
      exec_d.nzp         = nzp_nxt;
      exec_d.w_control   = W_control_in;
      exec_d.mem_control = Mem_control_in;
      exec_d.m_data      = op2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) exec_q <= '0;
    else        exec_q <= exec_d;
  end

  assign aluout          = exec_q.aluout;
  assign pcout           = exec_q.pcout;
  assign dr              = exec_q.dr;
  assign IR_Exec         = exec_q.ir;
  assign NZP             = exec_q.nzp;
  assign W_control_out   = exec_q.w_control;
  assign Mem_control_out = exec_q.mem_control;
  assign M_Data          = exec_q.m_data;

endmodule

// File: tb/tb_lc3_execute.sv
// Directed + random bench for lc3_execute with an expected-result queue.
module tb_lc3_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [15:0] IR, npc_in, VSR1, VSR2, Mem_bypass_val;
  logic [5:0]  E_control;
  logic [1:0]  W_control_in;
  logic        Mem_control_in;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [15:0] aluout, pcout, IR_Exec, M_Data;
  logic [2:0]  dr, sr1, sr2, NZP;
  logic [1:0]  W_control_out;
  logic        Mem_control_out;

  typedef struct packed {
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [2:0]  dr;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic [1:0]  w;
    logic        m;
    logic [15:0] mdata;
  } exp_t;

  exp_t sb[$];
  exp_t m_prev;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  lc3_execute dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute),
    .IR(IR), .npc_in(npc_in), .E_control(E_control),
    .W_control_in(W_control_in), .Mem_control_in(Mem_control_in),
    .VSR1(VSR1), .VSR2(VSR2),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .Mem_bypass_val(Mem_bypass_val),
    .aluout(aluout), .pcout(pcout), .dr(dr), .sr1(sr1), .sr2(sr2),
    .IR_Exec(IR_Exec), .NZP(NZP), .W_control_out(W_control_out),
    .Mem_control_out(Mem_control_out), .M_Data(M_Data)
  );

  task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp_all(input string ctx, input exp_t e);
    cmp({ctx, ".aluout"}, aluout, e.aluout);
    cmp({ctx, ".pcout"},  pcout,  e.pcout);
    cmp({ctx, ".dr"},     16'(dr), 16'(e.dr));
    cmp({ctx, ".IR_Exec"}, IR_Exec, e.ir);
    cmp({ctx, ".NZP"},    16'(NZP), 16'(e.nzp));
    cmp({ctx, ".W_ctl"},  16'(W_control_out), 16'(e.w));
    cmp({ctx, ".M_ctl"},  16'(Mem_control_out), 16'(e.m));
    cmp({ctx, ".M_Data"}, M_Data, e.mdata);
  endtask

  // Reference behaviour of one enabled capture
  function automatic exp_t model(input logic [15:0] ir, npc, input logic [5:0] ec,
                                 input logic [1:0] w, input logic m,
                                 input logic [15:0] v1, v2,
                                 input logic ba1, ba2, bm1, bm2,
                                 input logic [15:0] mbv, prev_alu);
    logic [15:0] a, b, opb, res, off, base, ea;
    exp_t r;
    a   = ba1 ? prev_alu : (bm1 ? mbv : v1);
    b   = ba2 ? prev_alu : (bm2 ? mbv : v2);
    opb = ec[0] ? b : {{11{ir[4]}}, ir[4:0]};
    case (ec[5:4])
      2'd0:    res = a + opb;
      2'd1:    res = a & opb;
      2'd2:    res = ~a;
      default: res = a;
    endcase
    case (ec[3:2])
      2'd0:    off = {{5{ir[10]}}, ir[10:0]};
      2'd1:    off = {{7{ir[8]}}, ir[8:0]};
      2'd2:    off = {{10{ir[5]}}, ir[5:0]};
      default: off = 16'h0000;
    endcase
    base = ec[1] ? npc : a;
    ea   = base + off;
    r = '0;
    r.pcout  = ea;
    r.aluout = (ir[15:12] == 4'hE) ? ea : res;
    r.ir = ir; r.w = w; r.m = m; r.mdata = b;
    case (ir[15:12])
      4'h1, 4'h5, 4'h9, 4'h2, 4'h6, 4'hA, 4'hE: r.dr = ir[11:9];
      default: r.dr = 3'd0;
    endcase
    if (ir[15:12] == 4'h0)      r.nzp = ir[11:9];
    else if (ir[15:12] == 4'hC) r.nzp = 3'b111;
    return r;
  endfunction

  task automatic step(input string tag, input logic en, input logic [15:0] ir, npc,
                      input logic [5:0] ec, input logic [1:0] w, input logic m,
                      input logic [15:0] v1, v2, input logic ba1, ba2, bm1, bm2,
                      input logic [15:0] mbv);
    exp_t e, got;
    logic [2:0] s2;
    @(negedge clock);
    enable_execute = en; IR = ir; npc_in = npc; E_control = ec;
    W_control_in = w; Mem_control_in = m; VSR1 = v1; VSR2 = v2;
    bypass_alu_1 = ba1; bypass_alu_2 = ba2; bypass_mem_1 = bm1; bypass_mem_2 = bm2;
    Mem_bypass_val = mbv;
    #1;
    s2 = (ir[15:12] == 4'h3 || ir[15:12] == 4'h7 || ir[15:12] == 4'hB) ? ir[11:9] : ir[2:0];
    cmp({tag, ".sr1"}, 16'(sr1), 16'(ir[8:6]));
    cmp({tag, ".sr2"}, 16'(sr2), 16'(s2));
    e = en ? model(ir, npc, ec, w, m, v1, v2, ba1, ba2, bm1, bm2, mbv, m_prev.aluout) : m_prev;
    m_prev = e;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    cmp_all(tag, got);
  endtask

  initial begin
    exp_t zero;
    zero = '0;
    m_prev = '0;
    reset = 1'b0; enable_execute = 1'b0; IR = '0; npc_in = '0; E_control = '0;
    W_control_in = '0; Mem_control_in = 1'b0; VSR1 = '0; VSR2 = '0;
    bypass_alu_1 = 1'b0; bypass_alu_2 = 1'b0; bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b0;
    Mem_bypass_val = '0;
    repeat (2) @(posedge clock);
    #1;
    cmp_all("reset", zero);
    @(negedge clock);
    reset = 1'b1;

    // ADD R3,R1,R2 overflowing into bit 15
    step("add", 1, 16'h1642, 16'h3000, 6'b000001, 2'b01, 1'b0, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h0);
    cmp("add.hand.aluout", aluout, 16'h8000);
    cmp("add.hand.dr", 16'(dr), 16'd3);
    step("and_imm", 1, 16'h5265, 16'h3001, 6'b010000, 2'b10, 1'b1, 16'h00FF, 16'hAAAA, 0, 0, 0, 0, 16'h0);
    cmp("and.hand.aluout", aluout, 16'h0005);
    step("not", 1, 16'h967F, 16'h3002, 6'b100000, 2'b00, 1'b0, 16'h1234, 16'h0, 0, 0, 0, 0, 16'h0);
    cmp("not.hand.aluout", aluout, 16'hEDCB);
    step("brz", 1, 16'h05FE, 16'h3001, 6'b000110, 2'b00, 1'b0, 16'h1111, 16'h2222, 0, 0, 0, 0, 16'h0);
    cmp("brz.hand.pcout", pcout, 16'h2FFF);
    cmp("brz.hand.nzp", 16'(NZP), 16'(3'b010));
    cmp("brz.hand.dr", 16'(dr), 16'd0);
    step("br_wrap", 1, 16'h0E02, 16'hFFFF, 6'b000110, 2'b00, 1'b0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0);
    cmp("wrap.hand.pcout", pcout, 16'h0001);
    step("lea", 1, 16'hE3FF, 16'h4000, 6'b000110, 2'b01, 1'b0, 16'h9999, 16'h0, 0, 0, 0, 0, 16'h0);
    cmp("lea.hand.aluout", aluout, 16'h3FFF);
    cmp("lea.hand.dr", 16'(dr), 16'd1);
    step("jmp", 1, 16'hC1C0, 16'h5000, 6'b001100, 2'b00, 1'b0, 16'h6000, 16'h0, 0, 0, 0, 0, 16'h0);
    cmp("jmp.hand.nzp", 16'(NZP), 16'(3'b111));
    cmp("jmp.hand.pcout", pcout, 16'h6000);

    // Produce 0xBEEF, then a store that sees both bypasses on operand 2
    step("mk_beef", 1, 16'h1040, 16'h0, 6'b110000, 2'b00, 1'b0, 16'hBEEF, 16'h0, 0, 0, 0, 0, 16'h0);
    step("str_byp", 1, 16'h7943, 16'h0, 6'b001000, 2'b00, 1'b1, 16'h1000, 16'h2222, 0, 1, 0, 1, 16'h1111);
    cmp("str.hand.mdata", M_Data, 16'hBEEF);
    step("mem_byp1", 1, 16'h1642, 16'h0, 6'b000001, 2'b11, 1'b0, 16'h5555, 16'h0003, 0, 0, 1, 0, 16'h0100);
    cmp("membyp.hand.aluout", aluout, 16'h0103);
    step("alu_byp1", 1, 16'h1642, 16'h0, 6'b000001, 2'b01, 1'b1, 16'h5555, 16'h0003, 1, 0, 1, 0, 16'h0100);
    cmp("alubyp.hand.aluout", aluout, 16'h0106);

    // Hold for three cycles with changing inputs, then recapture
    for (int i = 0; i < 3; i++)
      step("hold", 0, 16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           16'($urandom));
    cmp("hold.hand.aluout", aluout, 16'h0106);
    step("reenable", 1, 16'h1642, 16'h3000, 6'b000001, 2'b01, 1'b0, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h0);
    cmp("reen.hand.aluout", aluout, 16'h8000);

    for (int i = 0; i < 24; i++)
      step("rand", ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 6'($urandom),
           2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));

    // Asynchronous reset in the middle of a cycle after a non-zero capture
    step("pre_rst", 1, 16'h967F, 16'h3002, 6'b100000, 2'b11, 1'b1, 16'h1234, 16'h4321, 0, 0, 0, 0, 16'h0);
    #2;
    reset = 1'b0;
    IR = 16'h3A00;
    #1;
    cmp_all("async_rst", zero);
    cmp("async_rst.sr1", 16'(sr1), 16'd0);
    cmp("async_rst.sr2", 16'(sr2), 16'd5);
    m_prev = '0;
    @(negedge clock);
    reset = 1'b1;
    step("post_rst", 1, 16'h5265, 16'h0, 6'b010000, 2'b10, 1'b1, 16'h00FF, 16'h0, 0, 0, 0, 0, 16'h0);
    cmp("post.hand.aluout", aluout, 16'h0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
